pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register with valid/ready flow control, flush-to-bubble and stall/bubble performance counters. It replaces the fixed-field, enable-only stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single generic block. Control bits and data are carried as two flat buses, and an optional skid buffer lets `o_ready` be driven from a register. It sits between any two pipeline stages and is also gated by the debug unit's global step enable.

## Interface
- `DATA_W`, 128, width of the payload bus (PC, operands, immediate, register indices).
- `CTRL_W`, 16, width of the control bus (reg_write, mem_write, branch, halt, ...). It is forced to zero whenever the stage holds no valid beat.
- `SKID`, 1. Selects the buffering mode:
  - 0: single register; `o_ready` is combinational.
  - 1: main register plus one skid entry; `o_ready` is registered.
- `CNT_W`, 16, width of each performance counter.

Ports:
- `i_clock`  in  1  clock. All state updates on the falling edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_pipeline_enable`  in  1  global debug step enable. When low, there are no transfers and no counter updates.
- `i_flush`  in  1  synchronous flush; inserts a bubble.
- `i_valid`  in  1  upstream beat valid.
- `o_ready`  out  1  stage can accept a beat.
- `i_ctrl`  in  CTRL_W  upstream control bits.
- `i_data`  in  DATA_W  upstream payload.
- `o_valid`  out  1  stage holds a valid beat.
- `i_ready`  in  1  downstream accepts.
- `o_ctrl`  out  CTRL_W  held control bits; zero when `o_valid`=0.
- `o_data`  out  DATA_W  held payload.
- `i_count_clear`  in  1  synchronous clear of both counters.
- `o_stall_count`  out  CNT_W  saturating count of stall cycles.
- `o_bubble_count`  out  CNT_W  saturating count of bubble cycles.

## Operation
- **Transfer definitions** (qualified by `i_pipeline_enable`):
  - in_fire = `i_valid` & `o_ready` & `i_pipeline_enable`.
  - out_fire = `o_valid` & `i_ready` & `i_pipeline_enable`.
- **`o_ready`**:
  - Forced 0 while `i_flush`=1 or `i_pipeline_enable`=0.
  - SKID=0: `o_ready` = !`o_valid` | `i_ready`.
  - SKID=1: `o_ready` = !skid_valid, taken from the register only.
- **SKID=0 main register**:
  - in_fire loads main.
  - out_fire without in_fire clears `o_valid`.
  - Otherwise the register holds.
- **SKID=1 states** (by {skid_valid, main_valid}):
  - EMPTY {0,0}: in_fire → ONE.
  - ONE {0,1}:
    - in_fire & out_fire → ONE, main loads the new beat.
    - in_fire only → FULL, the new beat goes to skid.
    - out_fire only → EMPTY.
  - FULL {1,1}: out_fire → ONE, skid moves to main. No in_fire is possible here.
- **Ordering**: beats leave strictly in arrival order; there is no loss and no duplication.
- **Flush**: acts regardless of `i_pipeline_enable` and overrides every transfer.
  - main_valid and skid_valid clear.
  - `o_data` and skid data hold their values (don't care).
  - Counters do not update in the flush cycle.
- **Bubble masking**: `o_ctrl` = main_ctrl & {CTRL_W{`o_valid`}}, so an invalid stage never asserts a write, branch or halt.
- **Counters**:
  - stall increments on enabled, non-flush cycles with `o_valid` & !`i_ready`.
  - bubble increments on enabled, non-flush cycles with !`o_valid`.
  - Both saturate at 2^CNT_W−1.
  - `i_count_clear` takes priority over increment.
  - `i_count_clear` is not gated by enable.
- **Enable low**: all state holds and `o_ready`=0. Downstream must gate its own `i_ready` use with the same enable.

## Timing
- **Reset** (asynchronous, any time, including mid-transfer): `o_valid`=0, skid_valid=0, `o_ctrl`=0, `o_data`=0, both counters=0.
  - SKID=1: `o_ready`=1 from the first enabled cycle after release.
  - SKID=0: `o_ready`=1 whenever enabled.
- **Latency**: a beat accepted at falling edge N appears on `o_valid`/`o_ctrl`/`o_data` after edge N. This is one falling edge of latency.
- **Throughput**: one beat per cycle sustained in both modes while `i_ready`=1.
- **SKID=1 backpressure**: `o_ready` falls one edge after the skid fills. The beat offered in that cycle is captured in skid, not lost.
- **Simultaneous flush and reset**: reset wins.
- **Simultaneous flush and count_clear**: counters clear.

## Test plan
- **Reset**: pulse `i_reset_n` low mid-stream while `o_valid`=1 and the skid is full → all outputs 0 immediately (asynchronously); `o_ready`=1 on the next enabled cycle.
- **Streaming**: SKID=1, data 1..8 streamed with `i_valid`=`i_ready`=1 → `o_data` 1..8 on consecutive cycles, one edge late; bubble_count=1 (first cycle only), stall_count=0.
- **Backpressure**: SKID=1, `i_ready`=0 while sending 0xA, 0xB → 0xA in main, 0xB in skid, `o_ready`=0. Then `i_ready`=1 → 0xA then 0xB out in order; `o_ready` returns to 1 after 0xA leaves.
- **Flush**: `i_flush` with the stage FULL and `i_ctrl`=0xFFFF → next cycle `o_valid`=0, `o_ctrl`=0x0000, `o_ready`=0 during the flush cycle, no counter change.
- **Debug enable**: `i_pipeline_enable`=0 for 5 cycles with `i_valid`=1 and `i_ready`=1 → state frozen, no transfers, counters unchanged. Re-enable → the stream resumes without loss.
- **Counter saturation**: CNT_W=4, `i_ready`=0 with `o_valid`=1 for 20 cycles → stall_count saturates at 15. Then `i_count_clear`=1 for one cycle → 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional skid entry,
// flush-to-bubble, debug step gating and saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_pipeline_enable,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_count_clear,
    output logic [CNT_W-1:0]  o_stall_count,
    output logic [CNT_W-1:0]  o_bubble_count
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;

    logic ready;
    logic in_fire;
    logic out_fire;
    logic count_en;

    always_comb begin
        if (SKID != 0) begin
            ready = i_pipeline_enable & ~i_flush & ~skid_valid_q;
        end else begin
            ready = i_pipeline_enable & ~i_flush & (~main_valid_q | i_ready);
        end
        in_fire  = i_valid & ready & i_pipeline_enable;
        out_fire = main_valid_q & i_ready & i_pipeline_enable;
        count_en = i_pipeline_enable & ~i_flush;
    end

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_ctrl_d  = main_ctrl_q;
        skid_ctrl_d  = skid_ctrl_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;

        if (i_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID == 0) begin
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = i_ctrl;
                main_data_d  = i_data;
            end else if (out_fire) begin
                main_valid_d = 1'b0;
            end
        end else if (skid_valid_q) begin
            // FULL: o_ready is low, so only a drain into main can happen
            if (out_fire) begin
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (main_valid_q && !out_fire) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = i_ctrl;
                skid_data_d  = i_data;
            end else begin
                main_valid_d = 1'b1;
                main_ctrl_d  = i_ctrl;
                main_data_d  = i_data;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (i_count_clear) begin
            stall_d  = '0;
            bubble_d = '0;
        end else if (count_en) begin
            if (main_valid_q && !i_ready && (stall_q != {CNT_W{1'b1}})) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (!main_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_d = bubble_q + CNT_W'(1);
            end
        end
    end

    always_ff @(negedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            skid_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            stall_q      <= '0;
            bubble_q     <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_ctrl_q  <= skid_ctrl_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            stall_q      <= stall_d;
            bubble_q     <= bubble_d;
        end
    end

    assign o_ready        = ready;
    assign o_valid        = main_valid_q;
    assign o_ctrl         = main_ctrl_q & {CTRL_W{main_valid_q}};
    assign o_data         = main_data_q;
    assign o_stall_count  = stall_q;
    assign o_bubble_count = bubble_q;

endmodule
